updown_seq_ctrl: RTL and testbench



---
 rtl/updown_pkg.sv | 25 ++
 rtl/updown_core.sv | 40 ++++
 rtl/updown_seq_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_updown_seq_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/updown_pkg.sv
// updown_pkg: shared definitions for the up/down sweep sequencer.
//   - Default widths and the dwell length.
//   - State encoding constants and the FSM state enum.
// Optional feature macro used by the design: UPDOWN_DWELL_EN (HOLD state).
package updown_pkg;

    localparam int unsigned DEF_WIDTH  = 4;
    localparam int unsigned DEF_PASS_W = 4;
    localparam int unsigned DEF_DWELL  = 2;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_UP   = 3'd1;
    localparam logic [2:0] ST_DN   = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        StIdle = ST_IDLE,
        StUp   = ST_UP,
        StDn   = ST_DN,
        StHold = ST_HOLD,
        StDone = ST_DONE
    } state_e;

endpackage

// File: rtl/updown_core.sv
// updown_core: loadable up/down counter datapath.
// Ports:
//   clk  - clock, rising edge
//   clr  - synchronous active-high clear (q -> 0)
//   en   - count one step in the direction given by up
//   up   - 1 = increment, 0 = decrement
//   load - load d into q; has priority over en
//   d    - load value
//   q    - counter value
module updown_core
    import updown_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end else if (en) begin
            r_q <= up ? (r_q + ONE) : (r_q - ONE);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/updown_seq_ctrl.sv
// updown_seq_ctrl: sweeps an up/down counter between latched bounds lo..hi for
// a latched number of endpoint arrivals, reversing at each endpoint.
// Ports:
//   clk, clr        - clock and synchronous active-high reset
//   start, abort    - begin a sweep (IDLE only) / terminate a sweep
//   lo, hi, passes  - sweep bounds and endpoint-arrival count, latched on start
//   q, up           - counter value and current direction
//   busy, done, err - sweep active / completion pulse / rejected-start pulse
// Macro UPDOWN_DWELL_EN: when defined (and DWELL != 0), every non-final endpoint
// is held for DWELL extra cycles in the HOLD state before reversing.
module updown_seq_ctrl
    import updown_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned PASS_W = DEF_PASS_W,
    parameter int unsigned DWELL  = DEF_DWELL
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [PASS_W-1:0] passes,
    output logic [WIDTH-1:0]  q,
    output logic              up,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [WIDTH-1:0]  ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PASS_W-1:0] ONE_P = {{(PASS_W-1){1'b0}}, 1'b1};

    state_e            r_state, w_state_next;
    logic [WIDTH-1:0]  r_lo, w_lo_next;
    logic [WIDTH-1:0]  r_hi, w_hi_next;
    logic [PASS_W-1:0] r_rem, w_rem_next;
    logic              r_up, w_up_next;
    logic              r_err, w_err_next;

    logic              w_load;
    logic              w_en;
    logic [WIDTH-1:0]  w_d;
    logic [WIDTH-1:0]  w_q;

`ifdef UPDOWN_DWELL_EN
    localparam bit          DWELL_ON = (DWELL != 0);
    localparam int unsigned DW_W     = (DWELL < 2) ? 1 : $clog2(DWELL + 1);
    localparam logic [DW_W-1:0] DW_INIT = DW_W'(DWELL);
    localparam logic [DW_W-1:0] DW_ONE  = {{(DW_W-1){1'b0}}, 1'b1};

    logic [DW_W-1:0] r_dwell, w_dwell_next;
`endif

    updown_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk  (clk),
        .clr  (clr),
        .en   (w_en),
        .up   (r_up),
        .load (w_load),
        .d    (w_d),
        .q    (w_q)
    );

    always_comb begin
        w_state_next = r_state;
        w_lo_next    = r_lo;
        w_hi_next    = r_hi;
        w_rem_next   = r_rem;
        w_up_next    = r_up;
        w_err_next   = 1'b0;
        w_load       = 1'b0;
        w_en         = 1'b0;
        w_d          = r_lo;
`ifdef UPDOWN_DWELL_EN
        w_dwell_next = r_dwell;
`endif

        unique case (r_state)
            StIdle: begin
                // abort in IDLE masks start entirely, including the err pulse
                if (start && !abort) begin
                    if ((lo >= hi) || (passes == '0)) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_lo_next    = lo;
                        w_hi_next    = hi;
                        w_rem_next   = passes;
                        w_up_next    = 1'b1;
                        w_load       = 1'b1;
                        w_d          = lo;
                        w_state_next = StUp;
                    end
                end
            end

            StUp: begin
                if (abort) begin
                    w_state_next = StIdle;
                end else if (w_q < r_hi) begin
                    w_en = 1'b1;
                end else begin
                    w_rem_next = r_rem - ONE_P;
                    if (r_rem == ONE_P) begin
                        w_state_next = StDone;
`ifdef UPDOWN_DWELL_EN
                    end else if (DWELL_ON) begin
                        w_dwell_next = DW_INIT;
                        w_state_next = StHold;
`endif
                    end else begin
                        w_up_next    = 1'b0;
                        w_load       = 1'b1;
                        w_d          = r_hi - ONE;
                        w_state_next = StDn;
                    end
                end
            end

            StDn: begin
                if (abort) begin
                    w_state_next = StIdle;
                end else if (w_q > r_lo) begin
                    w_en = 1'b1;
                end else begin
                    w_rem_next = r_rem - ONE_P;
                    if (r_rem == ONE_P) begin
                        w_state_next = StDone;
`ifdef UPDOWN_DWELL_EN
                    end else if (DWELL_ON) begin
                        w_dwell_next = DW_INIT;
                        w_state_next = StHold;
`endif
                    end else begin
                        w_up_next    = 1'b1;
                        w_load       = 1'b1;
                        w_d          = r_lo + ONE;
                        w_state_next = StUp;
                    end
                end
            end

`ifdef UPDOWN_DWELL_EN
            StHold: begin
                // r_up still holds the direction of arrival; reverse on the last dwell cycle
                if (abort) begin
                    w_state_next = StIdle;
                end else if (r_dwell == DW_ONE) begin
                    w_load = 1'b1;
                    if (r_up) begin
                        w_up_next    = 1'b0;
                        w_d          = r_hi - ONE;
                        w_state_next = StDn;
                    end else begin
                        w_up_next    = 1'b1;
                        w_d          = r_lo + ONE;
                        w_state_next = StUp;
                    end
                end else begin
                    w_dwell_next = r_dwell - DW_ONE;
                end
            end
`endif

            StDone: begin
                w_state_next = StIdle;
            end

            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= StIdle;
            r_lo    <= '0;
            r_hi    <= '0;
            r_rem   <= '0;
            r_up    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_lo    <= w_lo_next;
            r_hi    <= w_hi_next;
            r_rem   <= w_rem_next;
            r_up    <= w_up_next;
            r_err   <= w_err_next;
        end
    end

`ifdef UPDOWN_DWELL_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            r_dwell <= '0;
        end else begin
            r_dwell <= w_dwell_next;
        end
    end
`endif

    assign q    = w_q;
    assign up   = r_up;
    assign busy = (r_state == StUp) || (r_state == StDn) || (r_state == StHold);
    assign done = (r_state == StDone);
    assign err  = r_err;

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// tb_updown_seq_ctrl: self-checking bench for updown_seq_ctrl.
// The reference model expands each accepted sweep into the list of expected
// per-cycle outputs, then replays that list (or drops it on abort/clear).
module tb_updown_seq_ctrl;

    localparam int unsigned TB_DWELL = 2;
`ifdef UPDOWN_DWELL_EN
    localparam int DW = TB_DWELL;
`else
    localparam int DW = 0;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] lo = '0;
    logic [3:0] hi = '0;
    logic [3:0] passes = '0;
    logic [3:0] q;
    logic       up;
    logic       busy;
    logic       done;
    logic       err;

    updown_seq_ctrl #(
        .WIDTH  (4),
        .PASS_W (4),
        .DWELL  (TB_DWELL)
    ) dut (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .abort  (abort),
        .lo     (lo),
        .hi     (hi),
        .passes (passes),
        .q      (q),
        .up     (up),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] q;
        logic       up;
        logic       busy;
        logic       done;
        logic       err;
    } obs_t;

    obs_t exp_q[$];
    obs_t cur = '0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   busy_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expand one accepted sweep into its full output trace from the rules.
    task automatic build(input int l, input int h, input int p);
        int  v   = l;
        bit  u   = 1'b1;
        int  rem = p;
        while (1) begin
            exp_q.push_back('{q: 4'(v), up: u, busy: 1'b1, done: 1'b0, err: 1'b0});
            if ((u && v == h) || (!u && v == l)) begin
                rem--;
                if (rem == 0) break;
                repeat (DW) exp_q.push_back('{q: 4'(v), up: u, busy: 1'b1, done: 1'b0, err: 1'b0});
                u = !u;
            end
            v = u ? v + 1 : v - 1;
        end
        exp_q.push_back('{q: 4'(v), up: u, busy: 1'b0, done: 1'b1, err: 1'b0});
    endtask

    task automatic model(input bit s, input bit a, input bit c,
                         input int l, input int h, input int p);
        if (c) begin
            exp_q.delete();
            cur = '0;
        end else if (cur.busy || cur.done) begin
            if (a) begin
                exp_q.delete();
                cur.busy = 1'b0;
                cur.done = 1'b0;
            end else if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
            end else begin
                cur.busy = 1'b0;
                cur.done = 1'b0;
            end
        end else begin
            cur.err = 1'b0;
            if (s && !a) begin
                if (l >= h || p == 0) begin
                    cur.err = 1'b1;
                end else begin
                    build(l, h, p);
                    cur = exp_q.pop_front();
                end
            end
        end
    endtask

    task automatic step(input bit s, input bit a, input bit c,
                        input int l, input int h, input int p);
        start  = s;
        abort  = a;
        clr    = c;
        lo     = 4'(l);
        hi     = 4'(h);
        passes = 4'(p);
        @(posedge clk);
        model(s, a, c, l, h, p);
        #1;
        chk("q",    32'(q),    32'(cur.q));
        chk("up",   32'(up),   32'(cur.up));
        chk("busy", 32'(busy), 32'(cur.busy));
        chk("done", 32'(done), 32'(cur.done));
        chk("err",  32'(err),  32'(cur.err));
        if (busy === 1'b1) busy_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // reset
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        idle(2);

        // basic 2..4, two passes; busy cycle count from the closed form
        busy_cnt = 0;
        step(1, 0, 0, 2, 4, 2);
        idle(6 + 2 * DW);
        chk("busy_total", 32'(busy_cnt), 32'(2 * (4 - 2) + 1 + DW * (2 - 1)));

        // rejected starts
        step(1, 0, 0, 5, 5, 3);
        idle(2);
        step(1, 0, 0, 1, 3, 0);
        idle(2);

        // full range, abort at q=7
        step(1, 0, 0, 0, 15, 1);
        idle(7);
        chk("q_before_abort", 32'(q), 32'd7);
        step(0, 1, 0, 0, 0, 0);
        idle(3);

        // full range to completion, no wrap
        busy_cnt = 0;
        step(1, 0, 0, 0, 15, 1);
        idle(20);
        chk("busy_full", 32'(busy_cnt), 32'd16);

        // start re-pulsed and bounds changed mid-sweep
        step(1, 0, 0, 1, 6, 3);
        for (int i = 0; i < 25; i++) step(1, 0, 0, $urandom_range(0, 15), $urandom_range(0, 15), 1);
        idle(3);

        // start and abort together in IDLE
        step(1, 1, 0, 2, 9, 2);
        idle(2);

        // clear mid-sweep
        step(1, 0, 0, 3, 12, 2);
        idle(4);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 199) == 0), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 3));
        end
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
